// File: rtl/qrd_skew_scheduler.sv
// qrd_skew_scheduler
// Feeds N-element input vectors into the N-row QRD-RLS systolic array.
// Each accepted vector is split into row-skewed load strobes and data, and
// a single valid token follows it through the array's processing latency.
// That token produces out_valid, and the drained pipeline produces the
// end-of-frame done pulse.

module qrd_skew_scheduler #(
    parameter int N           = 3,
    parameter int DATA_LENGTH = 8,
    parameter int LATENCY     = 21,
    parameter int II          = 1,
    parameter int NUM_SAMPLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [N*DATA_LENGTH-1:0]           in_data,
    output logic                               in_ready,
    output logic [N-1:0]                       row_en,
    output logic [N*DATA_LENGTH-1:0]           row_data,
    output logic                               out_valid,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_idx,
    output logic                               busy,
    output logic                               done
);

    // The token for a vector sits in the last stage exactly when the array
    // result for that vector becomes available.
    localparam int DEPTH = LATENCY + N - 1;
    localparam int SW    = $clog2(NUM_SAMPLES + 1);
    localparam int IIW   = (II > 1) ? $clog2(II) : 1;

    localparam logic [SW-1:0]  FRAME_LEN = SW'(NUM_SAMPLES);
    localparam logic [IIW-1:0] II_RELOAD = IIW'(II - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state;
    logic [IIW-1:0]            ii_cnt;
    logic [DEPTH-1:0]          tok;
    logic                      accept;
    logic                      flush_act;
    logic                      pipe_empty_next;
    logic [N-1:0]              tap_v;
    logic [N-1:0]              skew_busy;
    logic [N*DATA_LENGTH-1:0]  tap_d;

    // in_ready is decoded from registered state only, so it never depends
    // on in_valid.
    assign in_ready  = (state == S_RUN) && (ii_cnt == '0) && (sample_idx < FRAME_LEN);
    // A flush in the same cycle discards the vector being offered.
    assign accept    = in_valid && in_ready && !flush;
    assign flush_act = flush && ((state == S_RUN) || (state == S_DRAIN));

    // Nothing enters the pipeline while draining, so the contents after this
    // edge are the current contents shifted by one. Looking one edge ahead
    // lets done follow the last out_valid directly.
    assign pipe_empty_next = ((tok << 1) == '0) && (skew_busy == '0);

    assign out_valid = tok[DEPTH-1];

    // Per-row skew: row k delays its element by k register stages.
    for (genvar k = 0; k < N; k++) begin : g_row
        logic [DATA_LENGTH-1:0] elem;

        // Data is zeroed when no vector is accepted, which keeps row_data at
        // 0 whenever the matching strobe is low.
        assign elem = accept ? in_data[k*DATA_LENGTH +: DATA_LENGTH] : '0;

        if (k == 0) begin : g_direct
            assign tap_v[k]                              = accept;
            assign tap_d[k*DATA_LENGTH +: DATA_LENGTH]   = elem;
            assign skew_busy[k]                          = 1'b0;
        end else begin : g_delay
            logic [k-1:0]           sv;
            logic [DATA_LENGTH-1:0] sd [k];

            // Shift row k's strobe and element through its k delay stages.
            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: the data stages are reset as well as the strobes, so
                // a reset or flush leaves no stale element in the skew path.
                if (!rst_n) begin
                    sv <= '0;
                    for (int j = 0; j < k; j++) sd[j] <= '0;
                end else if (flush_act) begin
                    sv <= '0;
                    for (int j = 0; j < k; j++) sd[j] <= '0;
                end else begin
                    sv[0] <= accept;
                    sd[0] <= elem;
                    for (int j = 1; j < k; j++) begin
                        sv[j] <= sv[j-1];
                        sd[j] <= sd[j-1];
                    end
                end
            end

            assign tap_v[k]                            = sv[k-1];
            assign tap_d[k*DATA_LENGTH +: DATA_LENGTH] = sd[k-1];
            assign skew_busy[k]                        = |sv;
        end
    end

    // Register the skewed strobes and elements onto the row outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always written with non-blocking
        // assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            row_en   <= '0;
            row_data <= '0;
        end else if (flush_act) begin
            row_en   <= '0;
            row_data <= '0;
        end else begin
            row_en   <= tap_v;
            row_data <= tap_d;
        end
    end

    // Valid-token pipeline: one token per accepted vector, shifted every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok <= '0;
        end else if (flush_act) begin
            tok <= '0;
        end else begin
            tok <= (tok << 1) | DEPTH'(accept);
        end
    end

    // Frame control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sample_idx <= '0;
            ii_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        sample_idx <= '0;
                        ii_cnt     <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state  <= S_IDLE;
                        ii_cnt <= '0;
                        busy   <= 1'b0;
                    end else if (accept) begin
                        sample_idx <= sample_idx + 1'b1;
                        ii_cnt     <= II_RELOAD;
                        if (sample_idx == FRAME_LEN - 1'b1) begin
                            state <= S_DRAIN;
                        end
                    end else if (ii_cnt != '0) begin
                        ii_cnt <= ii_cnt - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (flush) begin
                        state  <= S_IDLE;
                        ii_cnt <= '0;
                        busy   <= 1'b0;
                    end else if (pipe_empty_next) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
